// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and BCD helper for the seven-segment output block
package seg7_pkg;

  localparam int NDIG       = 8;
  localparam int BCD_DIGITS = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } seg7_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low, bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Double-dabble correction: every digit >= 5 gets +3 before the shift
  function automatic logic [4*BCD_DIGITS-1:0] dd_adjust(input logic [4*BCD_DIGITS-1:0] b);
    logic [4*BCD_DIGITS-1:0] r;
    r = b;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (b[4*d +: 4] >= 4'd5) r[4*d +: 4] = b[4*d +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_bcd_out_if.sv
// rtl/seg7_bcd_out_if.sv - CPU-side write port and status of the seven-segment output block
interface seg7_bcd_out_if;

  logic        wr_en;
  logic [31:0] wr_data;
  logic        hex_mode;
  logic        busy;
  logic        ovf;

  modport master (
    output wr_en, wr_data, hex_mode,
    input  busy, ovf
  );

  modport slave (
    input  wr_en, wr_data, hex_mode,
    output busy, ovf
  );

endinterface

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - one digit to active-low segments; dash overrides blank, blank overrides digit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  input  logic       dash_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[digit_i];
    if (dash_i)       seg_o = SEG_DASH;
    else if (blank_i) seg_o = SEG_BLANK;
  end

endmodule

// File: rtl/seg7_bcd_out.sv
// rtl/seg7_bcd_out.sv - 32-bit value to eight seven-segment digits, decimal via sequential double-dabble or raw hex
module seg7_bcd_out
  import seg7_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_bcd_out_if.slave  bus,
  output logic [6:0]     HEX0,
  output logic [6:0]     HEX1,
  output logic [6:0]     HEX2,
  output logic [6:0]     HEX3,
  output logic [6:0]     HEX4,
  output logic [6:0]     HEX5,
  output logic [6:0]     HEX6,
  output logic [6:0]     HEX7
);

  localparam int BCD_W = 4 * BCD_DIGITS;

  seg7_state_t       state_q, state_d;
  logic [31:0]       bin_q, bin_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       disp_q, disp_d;
  logic              hex_q, hex_d;
  logic              ovf_q, ovf_d;

  logic [BCD_W-1:0]  shifted;
  logic              last_shift;

  assign shifted    = {dd_adjust(bcd_q)[BCD_W-2:0], bin_q[31]};
  assign last_shift = (state_q == S_CONV) && (cnt_q == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      hex_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      hex_q   <= hex_d;
      ovf_q   <= ovf_d;
    end
  end

  // A write always wins over an in-flight conversion, either mode
  always_comb begin
    state_d = state_q;
    if (bus.wr_en)       state_d = bus.hex_mode ? S_IDLE : S_CONV;
    else if (last_shift) state_d = S_IDLE;
  end

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    hex_d  = hex_q;
    ovf_d  = ovf_q;
    if (bus.wr_en) begin
      if (bus.hex_mode) begin
        disp_d = bus.wr_data;
        hex_d  = 1'b1;
        ovf_d  = 1'b0;
      end else begin
        bin_d = bus.wr_data;
        bcd_d = '0;
        cnt_d = '0;
      end
    end else if (state_q == S_CONV) begin
      bcd_d = shifted;
      bin_d = {bin_q[30:0], 1'b0};
      cnt_d = cnt_q + 5'd1;
      if (last_shift) begin
        disp_d = shifted[31:0];
        ovf_d  = |shifted[BCD_W-1:32];
        hex_d  = 1'b0;
      end
    end
  end

  always_comb begin
    bus.busy = (state_q == S_CONV);
  end

  assign bus.ovf = ovf_q;

  // A digit blanks when it and every digit above it are zero; HEX0 always shows
  logic [NDIG-1:0] blank;
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    blank    = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp_q[4*i +: 4] == 4'd0);
      blank[i] = LZ_BLANK && !hex_q && all_zero && (i != 0);
    end
  end

  logic [6:0] seg [NDIG];

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    seg7_decode u_dec (
      .digit_i (disp_q[4*g +: 4]),
      .blank_i (blank[g]),
      .dash_i  (ovf_q),
      .seg_o   (seg[g])
    );
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];
  assign HEX6 = seg[6];
  assign HEX7 = seg[7];

endmodule

// File: tb/tb_seg7_bcd_out.sv
// tb/tb_seg7_bcd_out.sv - directed self-checking bench for seg7_bcd_out
module tb_seg7_bcd_out;

  logic       clk;
  logic       rst_n;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [6:0] hex [8];

  int total;
  int bad;

  seg7_bcd_out_if bus ();

  seg7_bcd_out #(.LZ_BLANK(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .HEX0  (HEX0),
    .HEX1  (HEX1),
    .HEX2  (HEX2),
    .HEX3  (HEX3),
    .HEX4  (HEX4),
    .HEX5  (HEX5),
    .HEX6  (HEX6),
    .HEX7  (HEX7)
  );

  assign hex[0] = HEX0;
  assign hex[1] = HEX1;
  assign hex[2] = HEX2;
  assign hex[3] = HEX3;
  assign hex[4] = HEX4;
  assign hex[5] = HEX5;
  assign hex[6] = HEX6;
  assign hex[7] = HEX7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // exp is HEX7..HEX0 packed, HEX7 in the top byte slot
  task automatic check_hex(input string tag, input logic [6:0] e7, e6, e5, e4, e3, e2, e1, e0);
    logic [6:0] exp [8];
    exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int i = 0; i < 8; i++) check($sformatf("%s.HEX%0d", tag, i), {25'd0, hex[i]}, {25'd0, exp[i]});
  endtask

  task automatic do_write(input logic [31:0] data, input logic hm);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_data  = data;
    bus.hex_mode = hm;
    @(posedge clk);
    #1;
    bus.wr_en    = 1'b0;
  endtask

  // Counts edges until busy drops; called #1 after the write edge
  task automatic wait_idle(output int n, output int hex0_changes, input logic [6:0] hold0);
    n = 0;
    hex0_changes = 0;
    while (bus.busy && n < 100) begin
      if (HEX0 !== hold0) hex0_changes++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n, chg;

  initial begin
    total = 0;
    bad   = 0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.hex_mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.ovf",  {31'd0, bus.ovf},  32'd0);
    check_hex("rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    do_write(32'd12345, 1'b0);
    check("d12345.busy_after_e0", {31'd0, bus.busy}, 32'd1);
    wait_idle(n, chg, 7'h40);
    check("d12345.busy_cycles", n, 32);
    check("d12345.hold", chg, 0);
    check("d12345.ovf", {31'd0, bus.ovf}, 32'd0);
    check_hex("d12345", 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12);

    do_write(32'hDEADBEEF, 1'b1);
    check("hex.busy", {31'd0, bus.busy}, 32'd0);
    check_hex("hex", 7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E);
    @(posedge clk);
    #1;
    check("hex.busy_later", {31'd0, bus.busy}, 32'd0);

    do_write(32'd100000000, 1'b0);
    wait_idle(n, chg, 7'h0E);
    check("ovf.busy_cycles", n, 32);
    check("ovf.flag", {31'd0, bus.ovf}, 32'd1);
    check_hex("ovf", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);

    do_write(32'd99999999, 1'b0);
    wait_idle(n, chg, 7'h3F);
    check("max.hold", chg, 0);
    check("max.ovf", {31'd0, bus.ovf}, 32'd0);
    check_hex("max", 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);

    do_write(32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    check("restart.busy_mid", {31'd0, bus.busy}, 32'd1);
    check_hex("restart.mid", 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10);
    do_write(32'd42, 1'b0);
    wait_idle(n, chg, 7'h10);
    check("restart.busy_cycles", n, 32);
    check("restart.hold", chg, 0);
    check_hex("restart", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24);

    do_write(32'd5, 1'b0);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.busy", {31'd0, bus.busy}, 32'd0);
    check("arst.ovf",  {31'd0, bus.ovf},  32'd0);
    check_hex("arst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("post.busy", {31'd0, bus.busy}, 32'd0);
    check("post.ovf",  {31'd0, bus.ovf},  32'd0);
    check_hex("post", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_out.md
# seg7_bcd_out

Output-side display peripheral for the CSCE611 RISC-V CPU. It accepts a 32-bit value written by the CPU's I/O register path, converts it to eight decimal digits with a sequential double-dabble engine, and drives HEX7..HEX0 with active-low seven-segment patterns. A hex mode bypasses the conversion. It moves the binary-to-decimal step out of software (bin2dec) and into hardware, feeding the board displays that the simulation top observes.

## Interface
- `LZ_BLANK`, default 1: when 1, blank leading zeros in decimal mode; HEX0 is never blanked.
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `wr_en`  input  1  single-cycle write strobe from the CPU I/O write.
- `wr_data`  input  32  value to display, sampled when `wr_en`=1.
- `hex_mode`  input  1  sampled with `wr_en`: 1 = raw hex nibbles, 0 = unsigned decimal.
- `busy`  output  1  decimal conversion in progress.
- `ovf`  output  1  last decimal value exceeded 99,999,999.
- `HEX0`..`HEX7`  output  7 each  active-low segments, bit0=a … bit6=g; HEX0 = least significant digit.

## Operation
- States: `IDLE`, `CONV`.
- `IDLE`, `wr_en`=1 and `hex_mode`=0:
  - Load the shift register with `wr_data`.
  - Clear the 40-bit BCD accumulator (10 digits).
  - Set the counter to 0 and go to `CONV`.
- `CONV`, each cycle:
  - Add 3 to every BCD digit that is ≥5.
  - Shift {BCD, bin} left by 1.
  - Increment the counter.
- `CONV` exit: on the 32nd shift (counter=31), latch the low 8 BCD digits into the display register.
  - Set `ovf` if either of the upper 2 digits is nonzero.
  - Latch mode=decimal and go to `IDLE`.
- `wr_en`=1 with `hex_mode`=1, in any state:
  - Display register ← `wr_data` nibbles (nibble i → HEX i). Mode=hex, `ovf`←0.
  - Go to `IDLE`; any conversion in progress is aborted.
- `wr_en`=1 with `hex_mode`=0 while in `CONV`: restart the conversion with the new value (latest write wins). The display keeps its old contents.
- Display decode, combinational from the display register, mode and `ovf`:
  - `ovf`=1: all eight digits show a dash (7'h3F).
  - Decimal mode: digits 0–9.
  - Hex mode: digits 0–F; blanking never applies.
  - Blanking (decimal mode, `LZ_BLANK`=1): digit i is blank (7'h7F) if it and all digits above it are 0, for i ≥ 1.
- Encodings, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - A=08, b=03, C=46, d=21, E=06, F=0E
- Reset values:
  - State `IDLE`, `busy`=0, `ovf`=0, display register 0, mode decimal.
  - With `LZ_BLANK`=1: HEX0=7'h40, HEX7..HEX1=7'h7F.

## Timing
- `wr_en` sampled at edge E0. `busy`=1 from E0 through E32 (32 cycles); `busy`=0 is asserted by the same edge that updates the display.
- Decimal latency: display and `ovf` are valid after edge E32, i.e. 32 cycles after the write edge.
- Hex latency: display is valid after edge E0; `busy` stays 0.
- Restart in `CONV`: the new 32-cycle window begins at the restart edge; `busy` stays 1 throughout.
- Reset asserted mid-`CONV`: immediately return to reset values. The partial result is discarded and is never displayed.
- `busy` = (state == `CONV`), registered state.
- `ovf` and the display register change only at latch or hex-load edges.

## Structure
- Package `seg7_pkg`:
  - state enum `seg7_state_t`.
  - 16-entry digit segment constant array, plus `SEG_BLANK`=7'h7F and `SEG_DASH`=7'h3F.
  - `NDIG`=8 and `BCD_DIGITS`=10.
- Sub-module `seg7_decode`: 4-bit digit, blank, dash → 7-bit active-low segments. Instantiated 8×.
- The double-dabble datapath stays inline in `seg7_bcd_out`.

## Test plan
- Reset only, `LZ_BLANK`=1 → HEX0=40, HEX7..HEX1=7F, `busy`=0.
- Write 12345, decimal → `busy` high for exactly 32 cycles. Then HEX4..HEX0 = 79,24,30,19,12; HEX7..HEX5=7F; `ovf`=0.
- Write 32'hDEADBEEF, hex → next cycle HEX7..HEX0 = 21,06,08,21,03,06,06,0E; `busy` stays 0.
- Write 100000000, decimal → after 32 cycles `ovf`=1 and all HEX=3F. Then write 99999999 → all HEX=10 and `ovf`=0.
- Write 7 decimal, then at cycle 10 write 42 decimal:
  - display unchanged until 32 cycles after the second write;
  - then HEX1=19, HEX0=24;
  - 7 is never shown.
- Write 5 decimal, pull `rst_n` low at cycle 15 of `CONV` → outputs return to reset values at once. Nothing else changes after release.
